// File: rtl/tdm_demultiplexer.sv
// tdm_demultiplexer: locks onto 4-slot TDM frames and publishes each completed frame as four parallel lanes.
module tdm_demultiplexer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             frame,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  output logic             locked,
  output logic             frame_err,
  output logic             address0,
  output logic             address1
);
  typedef enum logic {HUNT, SYNC} state_t;
  state_t           r_state, w_state;
  logic [1:0]       r_slot, w_slot;
  logic [WIDTH-1:0] r_hold0, r_hold1, r_hold2, w_hold0, w_hold1, w_hold2;
  logic [WIDTH-1:0] r_out0, r_out1, r_out2, r_out3;
  logic [WIDTH-1:0] w_out0, w_out1, w_out2, w_out3;
  logic             r_out_valid, r_frame_err, w_out_valid, w_frame_err;
  always_comb begin
    w_state     = r_state;
    w_slot      = r_slot;
    w_hold0     = r_hold0;
    w_hold1     = r_hold1;
    w_hold2     = r_hold2;
    w_out0      = r_out0;
    w_out1      = r_out1;
    w_out2      = r_out2;
    w_out3      = r_out3;
    w_out_valid = 1'b0;
    w_frame_err = 1'b0;
    if (in_valid) begin
      if (r_state == HUNT) begin
        if (frame) begin
          w_hold0 = in;
          w_slot  = 2'd1;
          w_state = SYNC;
        end
      end else if (frame) begin
        // an early frame marker restarts the frame at slot 0
        w_frame_err = (r_slot != 2'd0);
        w_hold0     = in;
        w_slot      = 2'd1;
      end else if (r_slot == 2'd0) begin
        w_frame_err = 1'b1;
        w_state     = HUNT;
      end else if (r_slot == 2'd3) begin
        w_out0      = r_hold0;
        w_out1      = r_hold1;
        w_out2      = r_hold2;
        w_out3      = in;
        w_out_valid = 1'b1;
        w_slot      = 2'd0;
      end else begin
        w_hold1 = (r_slot == 2'd1) ? in : r_hold1;
        w_hold2 = (r_slot == 2'd2) ? in : r_hold2;
        w_slot  = r_slot + 2'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_slot      <= '0;
      r_hold0     <= '0;
      r_hold1     <= '0;
      r_hold2     <= '0;
      r_out0      <= '0;
      r_out1      <= '0;
      r_out2      <= '0;
      r_out3      <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_slot      <= w_slot;
      r_hold0     <= w_hold0;
      r_hold1     <= w_hold1;
      r_hold2     <= w_hold2;
      r_out0      <= w_out0;
      r_out1      <= w_out1;
      r_out2      <= w_out2;
      r_out3      <= w_out3;
      r_out_valid <= w_out_valid;
      r_frame_err <= w_frame_err;
    end
  end
  assign out0      = r_out0;
  assign out1      = r_out1;
  assign out2      = r_out2;
  assign out3      = r_out3;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;
  assign locked    = (r_state == SYNC);
  assign address0  = r_slot[0];
  assign address1  = r_slot[1];
endmodule

// File: tb/tb_tdm_demultiplexer.sv
// tb_tdm_demultiplexer: directed frames with hand-computed lane words and status flags.
module tb_tdm_demultiplexer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic frame = 1'b0;
  logic in = 1'b0;
  logic out0, out1, out2, out3, out_valid, locked, frame_err, address0, address1;
  logic [3:0] lanes;
  logic [4:0] st;
  int checks = 0;
  int errors = 0;
  tdm_demultiplexer #(.WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .frame(frame), .in(in),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .locked(locked), .frame_err(frame_err),
    .address0(address0), .address1(address1)
  );
  always #5 clk = ~clk;
  // st = {out_valid, locked, frame_err, address1, address0}
  assign lanes = {out0, out1, out2, out3};
  assign st    = {out_valid, locked, frame_err, address1, address0};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic smp(input logic v, input logic f, input logic d);
    in_valid = v;
    frame    = f;
    in       = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_lanes", lanes, 4'b0000);
    chk("rst_st", st, 5'b00000);
    smp(0, 0, 0);
    chk("idle_st", st, 5'b00000);
    // HUNT discard then frame 0,1,0,1
    smp(1, 0, 1); smp(1, 0, 1); smp(1, 0, 1);
    chk("hunt_st", st, 5'b00000);
    smp(1, 1, 0); chk("hunt_lock", st, 5'b01001);
    smp(1, 0, 1); chk("hunt_s1", st, 5'b01010);
    smp(1, 0, 0); chk("hunt_s2", st, 5'b01011);
    smp(1, 0, 1); chk("hunt_pub", st, 5'b11000);
    chk("hunt_lanes", lanes, 4'b0101);
    smp(0, 1, 0); chk("pub_drop", st, 5'b01000);
    chk("pub_hold", lanes, 4'b0101);
    // nominal frame 1,0,1,1
    smp(1, 1, 1); chk("nom_a1", st, 5'b01001);
    smp(1, 0, 0); chk("nom_a2", st, 5'b01010);
    smp(1, 0, 1); chk("nom_a3", st, 5'b01011);
    smp(1, 0, 1); chk("nom_pub", st, 5'b11000);
    chk("nom_lanes", lanes, 4'b1011);
    // back-to-back frame 0,1,1,1 with a 2-cycle gap before slot 2
    smp(1, 1, 0); chk("b2b_s0", st, 5'b01001);
    smp(1, 0, 1);
    smp(0, 0, 0); smp(0, 1, 0);
    chk("gap_st", st, 5'b01010);
    smp(1, 0, 1);
    smp(1, 0, 1); chk("b2b_pub", st, 5'b11000);
    chk("b2b_lanes", lanes, 4'b0111);
    // early frame after slots 0,1
    smp(1, 1, 1); smp(1, 0, 0);
    smp(1, 1, 1); chk("early_err", st, 5'b01101);
    chk("early_hold", lanes, 4'b0111);
    smp(1, 0, 0); chk("early_s1", st, 5'b01010);
    smp(1, 0, 0);
    smp(1, 0, 1); chk("early_pub", st, 5'b11000);
    chk("early_lanes", lanes, 4'b1001);
    // missing frame at slot 0
    smp(1, 0, 1); chk("miss_err", st, 5'b00100);
    chk("miss_hold", lanes, 4'b1001);
    smp(0, 0, 0); chk("miss_clr", st, 5'b00000);
    smp(1, 0, 1); chk("miss_hunt", st, 5'b00000);
    smp(1, 1, 1); chk("relock", st, 5'b01001);
    smp(1, 0, 1); smp(1, 0, 0);
    smp(1, 0, 0); chk("relock_pub", st, 5'b11000);
    chk("relock_lanes", lanes, 4'b1100);
    // async reset mid-frame
    smp(1, 1, 0); smp(1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lanes", lanes, 4'b0000);
    chk("arst_st", st, 5'b00000);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    smp(0, 0, 0); smp(0, 0, 0);
    chk("arst_idle_st", st, 5'b00000);
    chk("arst_idle_lanes", lanes, 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
